// File: rtl/seq_muldiv.sv
// ---------------------------------------------------------------------------
// seq_muldiv -- sequential multiplier / divider
//
// One operation at a time. Multiply is shift-add and divide is restoring,
// one bit per clock. Signed operations work on magnitudes and correct the
// sign once the iterations are finished.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, a multiply stops iterating once the remaining multiplier
//   magnitude is zero (always at least one iteration). Divide is unaffected.
//
// Ports
//   CLK    in   rising-edge clock
//   RST    in   synchronous active-high reset, wins over CE
//   CE     in   clock enable; low freezes every register
//   START  in   start request, accepted only while idle
//   OP     in   00 umul, 01 smul, 10 udiv, 11 sdiv
//   A, B   in   multiplicand/dividend, multiplier/divisor
//   BUSY   out  high in PREP, ITER and FIX
//   DONE   out  one-cycle pulse in the cycle after FIX
//   LO     out  product low half or quotient
//   HI     out  product high half or remainder
//   DZ     out  divide-by-zero flag of the last operation
// ---------------------------------------------------------------------------
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] HI,
    output logic             DZ
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        ITER = 2'b10,
        FIX  = 2'b11
    } state_t;

    state_t             state_r;
    logic [1:0]         op_r;          // op_r[1]: divide, op_r[0]: signed
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    // Multiply: x_r is the left-shifting multiplicand, acc_r the product.
    // Divide:   x_r low half shifts the dividend out and the quotient in,
    //           acc_r low half is the partial remainder.
    logic [2*WIDTH-1:0] x_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   y_r;           // multiplier (shifting) or divisor
    logic [CW-1:0]      cnt_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic               dz_pend_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] mul_acc_s;
    logic [WIDTH-1:0]   y_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic               div_bit_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic               last_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Operand signs and magnitudes consumed in PREP
    always_comb begin
        a_neg_s = op_r[0] & a_r[WIDTH-1];
        b_neg_s = op_r[0] & b_r[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = -a_r;
        end else begin
            a_mag_s = a_r;
        end
        if (b_neg_s) begin
            b_mag_s = -b_r;
        end else begin
            b_mag_s = b_r;
        end
    end

    // One iteration step for both multiply and divide
    always_comb begin
        if (y_r[0]) begin
            mul_acc_s = acc_r + x_r;
        end else begin
            mul_acc_s = acc_r;
        end
        y_next_s = {1'b0, y_r[WIDTH-1:1]};

        // Trial subtraction; the top bit of the difference is the borrow.
        div_shift_s = {acc_r[WIDTH-1:0], x_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, y_r};
        div_bit_s   = ~div_diff_s[WIDTH];
        if (div_bit_s) begin
            div_rem_s = div_diff_s[WIDTH-1:0];
        end else begin
            div_rem_s = div_shift_s[WIDTH-1:0];
        end

`ifdef MULDIV_EARLY_OUT_EN
        last_s = (cnt_r == CW'(WIDTH - 1)) | (~op_r[1] & ~(|y_next_s));
`else
        last_s = (cnt_r == CW'(WIDTH - 1));
`endif
    end

    // Sign correction applied in FIX; remainder follows the dividend sign
    always_comb begin
        if (neg_res_r) begin
            prod_s = -acc_r;
            quo_s  = -x_r[WIDTH-1:0];
        end else begin
            prod_s = acc_r;
            quo_s  = x_r[WIDTH-1:0];
        end
        if (neg_rem_r) begin
            rem_s = -acc_r[WIDTH-1:0];
        end else begin
            rem_s = acc_r[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            op_r      <= 2'b00;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            x_r       <= {(2*WIDTH){1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            y_r       <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_pend_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_r      <= 1'b0;
            lo_r      <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
        end else if (CE) begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (START) begin
                        op_r    <= OP;
                        a_r     <= A;
                        b_r     <= B;
                        busy_r  <= 1'b1;
                        state_r <= PREP;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                PREP: begin
                    neg_res_r <= a_neg_s ^ b_neg_s;
                    neg_rem_r <= a_neg_s;
                    x_r       <= {{WIDTH{1'b0}}, a_mag_s};
                    y_r       <= b_mag_s;
                    acc_r     <= {(2*WIDTH){1'b0}};
                    cnt_r     <= {CW{1'b0}};
                    // A zero divisor goes straight to FIX.
                    if (op_r[1] && (b_r == {WIDTH{1'b0}})) begin
                        dz_pend_r <= 1'b1;
                        state_r   <= FIX;
                    end else begin
                        dz_pend_r <= 1'b0;
                        state_r   <= ITER;
                    end
                end
                ITER: begin
                    if (op_r[1]) begin
                        acc_r <= {{WIDTH{1'b0}}, div_rem_s};
                        x_r   <= {{WIDTH{1'b0}}, x_r[WIDTH-2:0], div_bit_s};
                    end else begin
                        acc_r <= mul_acc_s;
                        x_r   <= {x_r[2*WIDTH-2:0], 1'b0};
                        y_r   <= y_next_s;
                    end
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= ITER;
                    end
                end
                FIX: begin
                    if (dz_pend_r) begin
                        lo_r <= {WIDTH{1'b1}};
                        hi_r <= a_r;
                        dz_r <= 1'b1;
                    end else if (op_r[1]) begin
                        lo_r <= quo_s;
                        hi_r <= rem_s;
                        dz_r <= 1'b0;
                    end else begin
                        lo_r <= prod_s[WIDTH-1:0];
                        hi_r <= prod_s[2*WIDTH-1:WIDTH];
                        dz_r <= 1'b0;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_r;
    assign DONE = done_r;
    assign LO   = lo_r;
    assign HI   = hi_r;
    assign DZ   = dz_r;

endmodule

// File: tb/tb_seq_muldiv.sv
module tb_seq_muldiv;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         CE;
    logic         START;
    logic [1:0]   OP;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] LO;
    logic [W-1:0] HI;
    logic         DZ;

    seq_muldiv #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .START(START), .OP(OP), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .LO(LO), .HI(HI), .DZ(DZ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           done_edge;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    logic ce_q     = 1'b0;

    // Count clock edges and remember whether each one was enabled
    always @(posedge CLK) begin
        edge_cnt <= edge_cnt + 1;
        ce_q     <= CE;
    end

    // Monitor: every fresh DONE pulse is matched against the scoreboard
    always @(negedge CLK) begin
        exp_t e;
        if (DONE === 1'b1 && ce_q && RST === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at edge %0d lo=%h hi=%h dz=%b", edge_cnt, LO, HI, DZ);
            end else begin
                e = sb.pop_front();
                checks++;
                if (LO !== e.lo || HI !== e.hi || DZ !== e.dz) begin
                    failures++;
                    $display("FAIL %s result got lo=%h hi=%h dz=%b exp lo=%h hi=%h dz=%b",
                             e.name, LO, HI, DZ, e.lo, e.hi, e.dz);
                end
                checks++;
                if (edge_cnt != e.done_edge) begin
                    failures++;
                    $display("FAIL %s done_edge got %0d exp %0d", e.name, edge_cnt, e.done_edge);
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Drive START at a negedge; expectation is pushed once the START edge is known.
    // lat counts enabled edges from the START edge to the edge raising DONE; stall adds disabled edges.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic edz,
                         input int lat, input int stall, input bit push, input string name);
        exp_t e;
        START = 1'b1; OP = op; A = a; B = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        if (push) begin
            e.lo = elo; e.hi = ehi; e.dz = edz;
            e.done_edge = edge_cnt + lat + stall - 1;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    // Wait until BUSY drops (returns at that negedge, i.e. in the DONE cycle)
    task automatic wait_idle(output int busy_n);
        busy_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (BUSY !== 1'b1) return;
            busy_n++;
        end
        checks++;
        failures++;
        $display("FAIL wait_idle timeout busy_cycles=%0d limit=200", busy_n);
    endtask

    function automatic int mlat(input int eo_lat);
        return EO ? eo_lat : W + 3;
    endfunction

    int bn;

    initial begin
        RST = 1'b1; CE = 1'b0; START = 1'b0; OP = 2'b00; A = '0; B = '0;
        // Reset must act even with CE low.
        repeat (3) @(negedge CLK);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_dz", {31'd0, DZ}, 32'd0);
        RST = 1'b0; CE = 1'b1;
        @(negedge CLK);

        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 35, 0, 1'b1, "umul_max");
        wait_idle(bn);
        check("umul_max_busy_cycles", bn, 32'd34);
        issue(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, mlat(6), 0, 1'b1, "smul_m3x7");
        wait_idle(bn);
        issue(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 35, 0, 1'b1, "sdiv_m7d2");
        wait_idle(bn);
        issue(2'b10, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b1, 3, 0, 1'b1, "udiv_by0");
        wait_idle(bn);
        check("udiv_by0_busy_cycles", bn, 32'd2);
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 35, 0, 1'b1, "sdiv_ovf");
        wait_idle(bn);
        issue(2'b10, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 35, 0, 1'b1, "udiv_1000d7");
        wait_idle(bn);
        issue(2'b01, 32'h80000000, 32'h80000000, 32'd0, 32'h40000000, 1'b0, 35, 0, 1'b1, "smul_minxmin");
        wait_idle(bn);
        issue(2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 3, 0, 1'b1, "sdiv_by0");
        wait_idle(bn);

        // Stray START mid-operation must be ignored; outputs hold the previous result.
        issue(2'b00, 32'd6, 32'h00010001, 32'h00060006, 32'd0, 1'b0, mlat(20), 0, 1'b1, "umul_ignore");
        repeat (3) @(negedge CLK);
        START = 1'b1; OP = 2'b10; A = 32'd1; B = 32'd0;
        @(negedge CLK);
        START = 1'b0;
        check("hold_lo", LO, 32'hFFFFFFFF);
        check("hold_hi", HI, 32'hFFFFFFFB);
        check("hold_dz", {31'd0, DZ}, 32'd1);
        wait_idle(bn);

        // Reset in the middle of an operation: no DONE, outputs cleared.
        issue(2'b00, 32'd3, 32'h00400000, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0, "abort");
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        check("abort_lo", LO, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_dz", {31'd0, DZ}, 32'd0);
        repeat (45) @(negedge CLK);
        issue(2'b00, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, mlat(6), 0, 1'b1, "umul_after_rst");
        wait_idle(bn);

        // CE low for 7 cycles mid-divide stretches latency by exactly 7.
        issue(2'b10, 32'hDEADBEEF, 32'h00001234, 32'h000C3BA5, 32'h0000076B, 1'b0, 35, 7, 1'b1, "udiv_stall");
        repeat (4) @(negedge CLK);
        CE = 1'b0;
        repeat (7) @(negedge CLK);
        check("stall_busy", {31'd0, BUSY}, 32'd1);
        CE = 1'b1;
        wait_idle(bn);
        // Issued in the DONE cycle of the previous operation.
        issue(2'b00, 32'd5, 32'd3, 32'd15, 32'd0, 1'b0, mlat(5), 0, 1'b1, "umul_5x3_b2b");
        wait_idle(bn);
        issue(2'b00, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, mlat(4), 0, 1'b1, "umul_5x0");
        wait_idle(bn);

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal 8..64).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  synchronous active-high reset.
REQ-004 SHALL have port CE  input  1  clock enable; low freezes all state.
REQ-005 SHALL have port START  input  1  request to start an operation.
REQ-006 SHALL have port OP  input  2  operation: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
REQ-007 SHALL have port A  input  WIDTH  multiplicand or dividend.
REQ-008 SHALL have port B  input  WIDTH  multiplier or divisor.
REQ-009 SHALL have port BUSY  output  1  high while an operation is in progress.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse when results are valid.
REQ-011 SHALL have port LO  output  WIDTH  product low half or quotient.
REQ-012 SHALL have port HI  output  WIDTH  product high half or remainder.
REQ-013 SHALL have port DZ  output  1  divide-by-zero flag for the last operation.

Function
REQ-014 SHALL implement states IDLE, PREP, ITER and FIX; every transition and register update SHALL occur only on CLK edges with CE=1.
REQ-015 SHALL accept START only in IDLE; it SHALL capture OP, A and B and go to PREP. START outside IDLE SHALL be ignored.
REQ-016 PREP SHALL convert signed operands to magnitudes and record the result sign; for signed div, the remainder sign SHALL follow the dividend.
REQ-017 ITER SHALL run exactly WIDTH cycles: shift-add for mul, restoring one-bit-per-cycle for div. It SHALL then go to FIX.
REQ-018 FIX SHALL apply the two's-complement sign correction, load LO, HI and DZ, and return to IDLE.
REQ-019 DONE SHALL be high for exactly the one cycle after FIX, so the START-to-DONE latency is WIDTH+3 enabled edges.
REQ-020 BUSY SHALL be high in PREP, ITER and FIX, and low in IDLE, including the DONE cycle.
REQ-021 A START in the DONE cycle SHALL be accepted.
REQ-022 Mul results SHALL be the full 2*WIDTH-bit product {HI,LO}, in two's complement for OP=01.
REQ-023 A zero divisor SHALL skip ITER (PREP to FIX) and set LO=all ones, HI=A and DZ=1. Its latency SHALL be 3.
REQ-024 DZ SHALL be 0 for every other operation.
REQ-025 Signed overflow (most-negative / -1) SHALL give LO=most-negative value, HI=0 and DZ=0.
REQ-026 LO, HI and DZ SHALL hold their values from the last FIX until the next FIX; they SHALL NOT change during PREP or ITER.
REQ-027 With CE=0 for any number of cycles, state, outputs and DONE SHALL be held, and latency SHALL stretch by exactly the number of disabled cycles.

Reset
REQ-028 RST=1 SHALL take priority over CE and act on the next CLK edge regardless of CE.
REQ-029 Reset SHALL force state=IDLE, BUSY=0, DONE=0, LO=0, HI=0 and DZ=0.
REQ-030 Reset during an operation SHALL abort it, with no DONE pulse and no partial result visible.

Configuration
REQ-031 When MULDIV_EARLY_OUT_EN is defined, multiply ITER SHALL end after the cycle in which the remaining multiplier magnitude becomes zero, with at least 1 iteration.
REQ-032 Under REQ-031, multiply latency SHALL be max(1, bit-length of |B|)+3.
REQ-033 When MULDIV_EARLY_OUT_EN is defined, divide timing and all results SHALL be identical to the macro-undefined behaviour.
REQ-034 When MULDIV_EARLY_OUT_EN is undefined, every non-zero-divisor operation SHALL take WIDTH+3 cycles.

Verification (WIDTH=32)
REQ-035 OP=00, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, DONE 35 cycles after START, BUSY high for 34 cycles.
REQ-036 OP=01, A=-3, B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; OP=11, A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 OP=10, A=100, B=0 -> DZ=1, LO=0xFFFFFFFF, HI=100, DONE 3 cycles after START; then OP=11, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, DZ=0.
REQ-038 Second START at cycle 5 of an op -> ignored, first result unchanged. RST at cycle 10 -> no DONE, outputs 0, next START completes normally.
REQ-039 CE held low 7 cycles mid-op -> DONE at cycle 42 with the correct result. Back-to-back START in the DONE cycle -> second DONE exactly 35 cycles later.
REQ-040 With MULDIV_EARLY_OUT_EN defined: OP=00, A=5, B=3 -> LO=15, HI=0, DONE at cycle 5; B=0 -> result 0 at cycle 4. Without the macro, both at cycle 35.
